// File: rtl/div_seq_param.sv
// rtl/div_seq_param.sv - multicycle restoring divider (DIV/DIVU), one quotient bit per clock
module div_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             sign_n_q, sign_n_d;
    logic             sign_d_q, sign_d_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    // Trial subtraction is one bit wider than the operands so a divisor with
    // its MSB set never loses the carry out of the shifted remainder.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d    = state_q;
        sign_n_d   = sign_n_q;
        sign_d_d   = sign_d_q;
        num_d      = num_q;
        den_d      = den_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        trial      = {rem_q, num_q[WIDTH-1]};
        diff       = trial - {1'b0, den_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_n_d = signed_op & dividend[WIDTH-1];
                    sign_d_d = signed_op & divisor[WIDTH-1];
                    num_d    = sign_n_d ? -dividend : dividend;
                    den_d    = sign_d_d ? -divisor : divisor;
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = CNT_INIT;
                    if (divisor == '0) begin
                        hi_d       = dividend;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Dividend bits are consumed MSB first by shifting num left.
                num_d = num_q << 1;
                if (trial >= {1'b0, den_q}) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = (sign_n_q ^ sign_d_q) ? -quo_q : quo_q;
                hi_d    = sign_n_q ? -rem_q : rem_q;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sign_n_q   <= 1'b0;
            sign_d_q   <= 1'b0;
            num_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_n_q   <= sign_n_d;
            sign_d_q   <= sign_d_d;
            num_q      <= num_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule
